// File: rtl/apb_master_mc.sv
// apb_master_mc: APB4 requester with address-decoded one-hot slave select,
// back-to-back transfers, strobes, error reporting and a wait-state timeout.
module apb_master_mc #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int SEL_LSB = 12,
  parameter int TIMEOUT = 16
) (
  input  logic                      pclk,
  input  logic                      presetn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_W-1:0]         cmd_addr,
  input  logic [DATA_W-1:0]         cmd_wdata,
  input  logic [DATA_W/8-1:0]       cmd_strb,
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      rsp_timeout,
  output logic [ADDR_W-1:0]         paddr,
  output logic                      pwrite,
  output logic [DATA_W-1:0]         pwdata,
  output logic [DATA_W/8-1:0]       pstrb,
  output logic [NUM_SLV-1:0]        psel,
  output logic                      penable,
  input  logic [NUM_SLV-1:0]        pready,
  input  logic [NUM_SLV*DATA_W-1:0] prdata,
  input  logic [NUM_SLV-1:0]        pslverr
);

  localparam int SW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TO_LAST =
    TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t            state;
  logic [SW-1:0]     idx;
  logic [SW-1:0]     cmd_idx;
  logic [TW-1:0]     wait_cnt;
  logic              dec_pend;
  logic              slv_ok;
  logic              sel_ready;
  logic              sel_err;
  logic [DATA_W-1:0] sel_rdata;
  logic              to_fire;
  logic              load;

  assign cmd_idx = cmd_addr[SEL_LSB +: SW];
  assign slv_ok  = {1'b0, cmd_idx} < (SW+1)'(NUM_SLV);

  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (idx == SW'(i)) begin
        sel_ready = pready[i];
        sel_err   = pslverr[i];
        sel_rdata = prdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign to_fire = (TIMEOUT != 0) && (state == ACCESS) &&
                   !sel_ready && (wait_cnt == TO_LAST);

  assign cmd_ready = (state == IDLE) ||
                     ((state == ACCESS) && sel_ready && !to_fire);

  assign load = cmd_valid && cmd_ready && slv_ok;

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state       <= IDLE;
      idx         <= '0;
      wait_cnt    <= '0;
      dec_pend    <= 1'b0;
      psel        <= '0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      pstrb       <= '0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_rdata   <= '0;
      unique case (state)
        IDLE: begin
          dec_pend <= 1'b0;
          if (dec_pend) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
          end
          // a queued decode error goes first; a new one waits a cycle
          if (cmd_valid && !slv_ok) begin
            if (dec_pend) begin
              dec_pend <= 1'b1;
            end else begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end
          end
        end
        SETUP: begin
          penable  <= 1'b1;
          wait_cnt <= '0;
          state    <= ACCESS;
        end
        ACCESS: begin
          if (sel_ready) begin
            rsp_valid <= 1'b1;
            rsp_err   <= sel_err;
            if (!pwrite && !sel_err) rsp_rdata <= sel_rdata;
            state     <= IDLE;
            psel      <= '0;
            penable   <= 1'b0;
            dec_pend  <= cmd_valid && !slv_ok;
          end else if (to_fire) begin
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            state       <= IDLE;
            psel        <= '0;
            penable     <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      if (load) begin
        state    <= SETUP;
        idx      <= cmd_idx;
        psel     <= NUM_SLV'(1) << cmd_idx;
        penable  <= 1'b0;
        pwrite   <= cmd_write;
        paddr    <= cmd_addr;
        pwdata   <= cmd_wdata;
        pstrb    <= cmd_write ? cmd_strb : '0;
        wait_cnt <= '0;
      end
    end
  end

endmodule
